// File: rtl/fetch_queue_if.sv
// Fetch-queue bundle: memory read handshake toward the memory port, and the
// instruction stream, redirect and occupancy toward decode.
interface fetch_queue_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] mem_addr;
    logic            mem_read;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_resp;
    logic            instr_valid;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;
    logic            instr_pop;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic [CW-1:0]   occupancy;

    modport master (
        output mem_addr, mem_read, instr_valid, instr, instr_pc, occupancy,
        input  mem_rdata, mem_resp, instr_pop, redirect, redirect_pc
    );

    modport slave (
        input  mem_addr, mem_read, instr_valid, instr, instr_pc, occupancy,
        output mem_rdata, mem_resp, instr_pop, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: issues sequential word reads and buffers up to
// DEPTH PC-tagged instructions with first-word fall-through toward decode.
module fetch_queue #(
    parameter int unsigned    XLEN     = 32,
    parameter int unsigned    DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h0000_1000)
) (
    input  logic                clk,
    input  logic                rst_n,
    fetch_queue_if.master       bus
);
    localparam int unsigned     PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned     CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]   FULL_C  = CW'(DEPTH);
    localparam logic [XLEN-1:0] STEP_C  = XLEN'(3'd4);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DROP = 2'b10
    } state_t;

    state_t          state_r;
    logic [XLEN-1:0] fetch_pc_r;
    logic [XLEN-1:0] addr_r;
    logic            mem_read_r;
    logic [CW-1:0]   count_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [PW-1:0]   wr_ptr_r;
    logic [XLEN-1:0] data_mem_r [DEPTH];
    logic [XLEN-1:0] pc_mem_r   [DEPTH];

    logic            pop_s;
    logic            push_s;
    logic [CW-1:0]   post_pop_count_s;
    logic [CW-1:0]   next_count_s;
    logic [XLEN-1:0] next_pc_s;
    logic [XLEN-1:0] redirect_target_s;

    // Queue bookkeeping; redirect overrides both pop and push
    always_comb begin
        pop_s             = 1'b0;
        push_s            = 1'b0;
        post_pop_count_s  = count_r;
        next_count_s      = count_r;
        next_pc_s         = fetch_pc_r + STEP_C;
        redirect_target_s = {bus.redirect_pc[XLEN-1:2], 2'b00};
        if (bus.redirect) begin
            pop_s  = 1'b0;
            push_s = 1'b0;
        end else begin
            pop_s  = bus.instr_pop && (count_r != '0);
            push_s = (state_r == REQ) && bus.mem_resp;
        end
        post_pop_count_s = count_r - CW'(pop_s);
        next_count_s     = post_pop_count_s + CW'(push_s);
    end

    // Fetch state machine with registered memory request outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            fetch_pc_r <= RESET_PC;
            addr_r     <= RESET_PC;
            mem_read_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.redirect) begin
                        fetch_pc_r <= redirect_target_s;
                    end else if (post_pop_count_s < FULL_C) begin
                        state_r    <= REQ;
                        mem_read_r <= 1'b1;
                        addr_r     <= fetch_pc_r;
                    end else begin
                        state_r    <= IDLE;
                    end
                end
                REQ: begin
                    if (bus.redirect) begin
                        fetch_pc_r <= redirect_target_s;
                        // The handshake cannot be abandoned; wait it out in DROP
                        if (bus.mem_resp) begin
                            state_r    <= IDLE;
                            mem_read_r <= 1'b0;
                        end else begin
                            state_r    <= DROP;
                        end
                    end else if (bus.mem_resp) begin
                        fetch_pc_r <= next_pc_s;
                        if (next_count_s < FULL_C) begin
                            addr_r     <= next_pc_s;
                        end else begin
                            state_r    <= IDLE;
                            mem_read_r <= 1'b0;
                        end
                    end else begin
                        state_r <= REQ;
                    end
                end
                DROP: begin
                    if (bus.redirect) begin
                        fetch_pc_r <= redirect_target_s;
                    end else begin
                        fetch_pc_r <= fetch_pc_r;
                    end
                    if (bus.mem_resp) begin
                        state_r    <= IDLE;
                        mem_read_r <= 1'b0;
                    end else begin
                        state_r    <= DROP;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    mem_read_r <= 1'b0;
                end
            endcase
        end
    end

    // Occupancy count and circular pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r  <= '0;
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
        end else if (bus.redirect) begin
            count_r  <= '0;
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
        end else begin
            count_r <= next_count_s;
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1'b1);
            end
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1'b1);
            end
        end
    end

    // Entry storage; contents are qualified by count, so no reset is needed
    always_ff @(posedge clk) begin
        if (push_s) begin
            data_mem_r[wr_ptr_r] <= bus.mem_rdata;
            pc_mem_r[wr_ptr_r]   <= fetch_pc_r;
        end
    end

    assign bus.mem_read    = mem_read_r;
    assign bus.mem_addr    = addr_r;
    assign bus.occupancy   = count_r;
    assign bus.instr_valid = (count_r != '0);
    assign bus.instr       = data_mem_r[rd_ptr_r];
    assign bus.instr_pc    = pc_mem_r[rd_ptr_r];
endmodule

// File: tb/tb_fetch_queue.sv
// Directed and randomized bench for fetch_queue against a queue-based
// reference model of the fetch/flush rules.
module tb_fetch_queue;
    localparam int unsigned XLEN     = 32;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_1000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } entry_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    fetch_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

    fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    entry_t      q[$];
    bit          m_busy;
    bit          m_drop;
    logic [31:0] m_addr;
    logic [31:0] m_npc;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_busy = 1'b0;
        m_drop = 1'b0;
        m_addr = RESET_PC;
        m_npc  = RESET_PC;
    endtask

    // One clock of the reference rules: flush beats pop/push, full queue stops fetching
    task automatic model_update(input bit pop, input bit resp, input bit redir,
                                input logic [31:0] rpc, input logic [31:0] rd);
        entry_t e;
        if (redir) begin
            q.delete();
            m_npc = {rpc[31:2], 2'b00};
            if (m_busy && !resp) begin
                m_drop = 1'b1;
            end else begin
                m_busy = 1'b0;
                m_drop = 1'b0;
            end
        end else begin
            if (pop && q.size() != 0) void'(q.pop_front());
            if (m_busy && resp) begin
                if (m_drop) begin
                    m_busy = 1'b0;
                    m_drop = 1'b0;
                end else begin
                    e.pc   = m_addr;
                    e.data = rd;
                    q.push_back(e);
                    m_npc = m_addr + 32'd4;
                    if (q.size() < DEPTH) m_addr = m_npc;
                    else m_busy = 1'b0;
                end
            end else if (!m_busy && q.size() < DEPTH) begin
                m_busy = 1'b1;
                m_addr = m_npc;
            end
        end
    endtask

    task automatic check_all();
        chk("mem_read", 32'(bus.mem_read), 32'(m_busy));
        if (m_busy) chk("mem_addr", bus.mem_addr, m_addr);
        chk("occupancy", 32'(bus.occupancy), 32'(q.size()));
        chk("instr_valid", 32'(bus.instr_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk("instr", bus.instr, q[0].data);
            chk("instr_pc", bus.instr_pc, q[0].pc);
        end
    endtask

    task automatic step(input bit pop, input bit resp, input bit redir, input logic [31:0] rpc);
        logic [31:0] rd;
        rd = $urandom();
        bus.instr_pop   = pop;
        bus.mem_resp    = resp;
        bus.redirect    = redir;
        bus.redirect_pc = rpc;
        bus.mem_rdata   = rd;
        @(posedge clk);
        model_update(pop, resp, redir, rpc, rd);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        bus.instr_pop = 1'b0;
        bus.mem_resp  = 1'b0;
        bus.redirect  = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_mem_read", 32'(bus.mem_read), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, RESET_PC);
        chk("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_occupancy", 32'(bus.occupancy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit p, r, f;
        bus.instr_pop   = 1'b0;
        bus.mem_resp    = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'd0;
        bus.mem_rdata   = 32'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Fill with immediate responses and no pops
        step(1'b0, 1'b0, 1'b0, 32'd0);
        chk("first_addr", bus.mem_addr, 32'h0000_1000);
        repeat (4) step(1'b0, 1'b1, 1'b0, 32'd0);
        chk("full_occupancy", 32'(bus.occupancy), 32'd4);
        chk("full_mem_read", 32'(bus.mem_read), 32'd0);
        chk("full_head_pc", bus.instr_pc, 32'h0000_1000);

        // Drain one per cycle; refetch resumes after the first pop
        step(1'b1, 1'b0, 1'b0, 32'd0);
        chk("refill_addr", bus.mem_addr, 32'h0000_1010);
        chk("refill_head_pc", bus.instr_pc, 32'h0000_1004);
        repeat (6) step(1'b1, 1'b1, 1'b0, 32'd0);

        // Redirect with a request in flight
        do_reset();
        step(1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        chk("inflight_addr", bus.mem_addr, 32'h0000_1004);
        step(1'b0, 1'b0, 1'b1, 32'h0000_2002);
        chk("drop_addr", bus.mem_addr, 32'h0000_1004);
        chk("drop_read", 32'(bus.mem_read), 32'd1);
        chk("drop_occupancy", 32'(bus.occupancy), 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b1, 1'b0, 32'd0);
        chk("drop_no_push", 32'(bus.occupancy), 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        chk("redirect_addr", bus.mem_addr, 32'h0000_2000);

        // Redirect coinciding with a response
        do_reset();
        step(1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b1, 1'b1, 32'h0000_3000);
        chk("flush_occupancy", 32'(bus.occupancy), 32'd0);
        chk("flush_valid", 32'(bus.instr_valid), 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        chk("flush_addr", bus.mem_addr, 32'h0000_3000);

        // Simultaneous pop and push at occupancy 2
        step(1'b0, 1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b1, 1'b0, 32'd0);
        chk("pp_occ_before", 32'(bus.occupancy), 32'd2);
        step(1'b1, 1'b1, 1'b0, 32'd0);
        chk("pp_occ_after", 32'(bus.occupancy), 32'd2);
        chk("pp_head_pc", bus.instr_pc, 32'h0000_3004);

        // Asynchronous reset with a request outstanding
        chk("pre_reset_read", 32'(bus.mem_read), 32'd1);
        do_reset();
        step(1'b0, 1'b0, 1'b0, 32'd0);
        chk("restart_addr", bus.mem_addr, 32'h0000_1000);

        // Randomized traffic with pop pressure varying by phase
        for (int i = 0; i < 800; i++) begin
            p = ($urandom_range(0, 3) < ((i / 100) % 4));
            r = ($urandom_range(0, 2) != 0);
            f = ($urandom_range(0, 24) == 0);
            step(p, r, f, $urandom());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
